// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared state encoding and display constants for the segment scan path
package seg_scan_driver_pkg;

    localparam int DISP_SEG_W      = 7;
    localparam int DISP_NUM_DIGITS = 9;
    localparam int DISP_SEL_W      = 4;

    localparam logic [DISP_SEG_W-1:0] SEG_OFF_ACTIVE_LOW  = 7'h7F;
    localparam logic [DISP_SEG_W-1:0] SEG_OFF_ACTIVE_HIGH = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } scan_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - loadable down-counter with zero flag, shared by the dwell and blank phases
module seg_scan_timer
    import seg_scan_driver_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Saturates at zero so a stray decrement never wraps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 7-segment scan controller with inter-digit blanking
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = DISP_NUM_DIGITS,
    parameter int SEL_W        = DISP_SEL_W,
    parameter int SEG_W        = DISP_SEG_W,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [SEG_W-1:0]      seg_in,
    output logic [SEL_W-1:0]      sel_out,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CNT_W     = $clog2(max3(DWELL_CYCLES, BLANK_CYCLES, 1)) + 1;
    localparam bit INV       = (ACTIVE_LOW != 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0]      DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LD = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
    localparam logic [SEG_W-1:0]      SEG_OFF  = {SEG_W{INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);
    localparam logic [SEL_W-1:0]      IDX_LAST = SEL_W'(NUM_DIGITS - 1);

    scan_state_t          state;
    logic [SEL_W-1:0]     idx;
    logic [SEL_W-1:0]     idx_next;
    logic [NUM_DIGITS-1:0] onehot;
    logic                 last;
    logic                 adv;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic                 tmr_dec;
    logic                 tmr_zero;

    seg_scan_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        last         = (idx == IDX_LAST);
        idx_next     = last ? '0 : idx + SEL_W'(1);
        onehot       = DIG_ONE << idx;
        adv          = tmr_zero && (((state == ST_SHOW) && !HAS_BLANK) || (state == ST_BLANK));
        tmr_load     = (state == ST_SETUP) || ((state == ST_SHOW) && tmr_zero && HAS_BLANK);
        tmr_load_val = (state == ST_SETUP) ? DWELL_LD : BLANK_LD;
        tmr_dec      = (state == ST_SHOW) || (state == ST_BLANK);
    end

    // Outputs are held at pin polarity; the inversion happens only on the way into these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            sel_out    <= '0;
            seg_out    <= SEG_OFF;
            dig_en     <= DIG_OFF;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_SETUP;
                        idx     <= '0;
                        sel_out <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    seg_out <= INV ? ~seg_in : seg_in;
                    dig_en  <= INV ? ~onehot : onehot;
                    state   <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (tmr_zero) begin
                        seg_out <= SEG_OFF;
                        dig_en  <= DIG_OFF;
                        if (HAS_BLANK) begin
                            state <= ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Step to the next digit; a dropped enable is honoured only here so no digit is cut short.
            if (adv) begin
                frame_done <= last;
                idx        <= idx_next;
                if (en) begin
                    state   <= ST_SETUP;
                    sel_out <= idx_next;
                end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed bench for seg_scan_driver with and without blanking
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       en_nb = 1'b0;
    logic       hold_mode = 1'b0;
    logic [6:0] tog_val = 7'h00;

    logic [3:0] sel_out, sel_nb;
    logic [6:0] seg_in, seg_in_nb, seg_out, seg_nb;
    logic [8:0] dig_en, dig_nb;
    logic       frame_done, fd_nb, busy, busy_nb;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign seg_in    = hold_mode ? tog_val : 7'h40 + 7'(sel_out);
    assign seg_in_nb = 7'h40 + 7'(sel_nb);

    seg_scan_driver #(
        .NUM_DIGITS(9), .SEL_W(4), .SEG_W(7),
        .DWELL_CYCLES(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
        .sel_out(sel_out), .seg_out(seg_out), .dig_en(dig_en),
        .frame_done(frame_done), .busy(busy)
    );

    seg_scan_driver #(
        .NUM_DIGITS(9), .SEL_W(4), .SEG_W(7),
        .DWELL_CYCLES(4), .BLANK_CYCLES(0), .ACTIVE_LOW(1)
    ) dut_nb (
        .clk(clk), .rst(rst), .en(en_nb), .seg_in(seg_in_nb),
        .sel_out(sel_nb), .seg_out(seg_nb), .dig_en(dig_nb),
        .frame_done(fd_nb), .busy(busy_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_setup(input int n);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(sel_out == 4'(n) && busy && dig_en == 9'h1FF) && k < 200);
        vectors++; if (k >= 200) begin miscompares++; $display("FAIL wait_setup_%0d got timeout want setup of digit %0d", n, n); end
    endtask

    task automatic wait_idle(input bit nb);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((nb ? busy_nb : busy) && k < 100);
        vectors++; if (k >= 100) begin miscompares++; $display("FAIL wait_idle_%0d got busy want idle", nb); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        tick(); tick(); tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL rst_dig got %h want 1ff", dig_en); end
        rst = 1'b0;
        tick();
        vectors++; if (seg_out !== 7'h7F) begin miscompares++; $display("FAIL rel_seg got %h want 7f", seg_out); end
        vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL rel_dig got %h want 1ff", dig_en); end
        vectors++; if (sel_out !== 4'd0) begin miscompares++; $display("FAIL rel_sel got %h want 0", sel_out); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rel_fd got %b want 0", frame_done); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rel_busy got %b want 1", busy); end
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        int start;
        int fd_cnt;
        logic [8:0] ed;
        logic [6:0] es;
        fd_cnt = 0;
        en = 1'b1;
        tick();
        start = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            ed = ~(9'd1 << i);
            es = ~(7'h40 + 7'(i));
            vectors++; if (sel_out !== 4'(i)) begin miscompares++; $display("FAIL ff_sel_%0d got %h want %h", i, sel_out, 4'(i)); end
            vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL ff_setup_dig_%0d got %h want 1ff", i, dig_en); end
            fd_cnt += int'(frame_done);
            for (int j = 0; j < 4; j++) begin
                tick();
                fd_cnt += int'(frame_done);
                vectors++; if (dig_en !== ed) begin miscompares++; $display("FAIL ff_lit_dig_%0d got %h want %h", i, dig_en, ed); end
                vectors++; if (seg_out !== es) begin miscompares++; $display("FAIL ff_lit_seg_%0d got %h want %h", i, seg_out, es); end
            end
            for (int j = 0; j < 2; j++) begin
                tick();
                fd_cnt += int'(frame_done);
                vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL ff_blank_dig_%0d got %h want 1ff", i, dig_en); end
                vectors++; if (seg_out !== 7'h7F) begin miscompares++; $display("FAIL ff_blank_seg_%0d got %h want 7f", i, seg_out); end
            end
        end
        vectors++; if (fd_cnt !== 0) begin miscompares++; $display("FAIL ff_early_fd got %0d want 0", fd_cnt); end
        tick();
        vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL ff_fd got %b want 1", frame_done); end
        vectors++; if (cyc - start !== 63) begin miscompares++; $display("FAIL ff_fd_time got %0d want 63", cyc - start); end
        vectors++; if (sel_out !== 4'd0) begin miscompares++; $display("FAIL ff_wrap_sel got %h want 0", sel_out); end
        en = 1'b0;
        tick();
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL ff_fd_pulse got %b want 0", frame_done); end
        wait_idle(1'b0);
    endtask

    task automatic test_hold();
        en = 1'b1;
        wait_setup(3);
        tick();
        vectors++; if (seg_out !== 7'h3C) begin miscompares++; $display("FAIL hold_cap got %h want 3c", seg_out); end
        hold_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tog_val = (i % 2 == 0) ? 7'h55 : 7'h2A;
            tick();
            vectors++; if (seg_out !== 7'h3C) begin miscompares++; $display("FAIL hold_seg_%0d got %h want 3c", i, seg_out); end
            vectors++; if (dig_en !== 9'h1F7) begin miscompares++; $display("FAIL hold_dig_%0d got %h want 1f7", i, dig_en); end
        end
        hold_mode = 1'b0;
        en = 1'b0;
        wait_idle(1'b0);
    endtask

    task automatic test_graceful_stop();
        en = 1'b1;
        wait_setup(5);
        tick();
        tick();
        en = 1'b0;
        vectors++; if (dig_en !== 9'h1DF) begin miscompares++; $display("FAIL gs_show2 got %h want 1df", dig_en); end
        for (int j = 0; j < 2; j++) begin
            tick();
            vectors++; if (dig_en !== 9'h1DF) begin miscompares++; $display("FAIL gs_lit_%0d got %h want 1df", j, dig_en); end
            vectors++; if (seg_out !== 7'h3A) begin miscompares++; $display("FAIL gs_seg_%0d got %h want 3a", j, seg_out); end
        end
        for (int j = 0; j < 2; j++) begin
            tick();
            vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL gs_dark_%0d got %h want 1ff", j, dig_en); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gs_busy_%0d got %b want 1", j, busy); end
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gs_idle_%0d got %b want 0", j, busy); end
            vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL gs_fd_%0d got %b want 0", j, frame_done); end
            vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL gs_off_%0d got %h want 1ff", j, dig_en); end
        end
    endtask

    task automatic test_reset_mid_scan();
        en = 1'b1;
        wait_setup(7);
        tick();
        tick();
        vectors++; if (dig_en !== 9'h17F) begin miscompares++; $display("FAIL rm_lit got %h want 17f", dig_en); end
        rst = 1'b1;
        tick();
        vectors++; if (dig_en !== 9'h1FF) begin miscompares++; $display("FAIL rm_dig got %h want 1ff", dig_en); end
        vectors++; if (seg_out !== 7'h7F) begin miscompares++; $display("FAIL rm_seg got %h want 7f", seg_out); end
        vectors++; if (sel_out !== 4'd0) begin miscompares++; $display("FAIL rm_sel got %h want 0", sel_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %b want 0", busy); end
        rst = 1'b0;
        tick();
        vectors++; if (busy !== 1'b1 || sel_out !== 4'd0) begin miscompares++; $display("FAIL rm_restart got busy=%b sel=%h want busy=1 sel=0", busy, sel_out); end
        tick();
        vectors++; if (dig_en !== 9'h1FE) begin miscompares++; $display("FAIL rm_d0_dig got %h want 1fe", dig_en); end
        vectors++; if (seg_out !== 7'h3F) begin miscompares++; $display("FAIL rm_d0_seg got %h want 3f", seg_out); end
        en = 1'b0;
        wait_idle(1'b0);
    endtask

    task automatic test_no_blank();
        int start;
        logic [8:0] ed;
        logic [6:0] es;
        en_nb = 1'b1;
        tick();
        start = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            ed = ~(9'd1 << i);
            es = ~(7'h40 + 7'(i));
            vectors++; if (sel_nb !== 4'(i) || dig_nb !== 9'h1FF) begin miscompares++; $display("FAIL nb_setup_%0d got sel=%h dig=%h want sel=%h dig=1ff", i, sel_nb, dig_nb, 4'(i)); end
            vectors++; if (fd_nb !== 1'b0 && i > 0) begin miscompares++; $display("FAIL nb_early_fd_%0d got %b want 0", i, fd_nb); end
            for (int j = 0; j < 4; j++) begin
                tick();
                vectors++; if (dig_nb !== ed) begin miscompares++; $display("FAIL nb_lit_dig_%0d got %h want %h", i, dig_nb, ed); end
                vectors++; if (seg_nb !== es) begin miscompares++; $display("FAIL nb_lit_seg_%0d got %h want %h", i, seg_nb, es); end
            end
        end
        tick();
        vectors++; if (fd_nb !== 1'b1) begin miscompares++; $display("FAIL nb_fd got %b want 1", fd_nb); end
        vectors++; if (cyc - start !== 45) begin miscompares++; $display("FAIL nb_fd_time got %0d want 45", cyc - start); end
        vectors++; if (sel_nb !== 4'd0) begin miscompares++; $display("FAIL nb_wrap_sel got %h want 0", sel_nb); end
        en_nb = 1'b0;
        wait_idle(1'b1);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_hold();
        test_graceful_stop();
        test_reset_mid_scan();
        test_no_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
